// File: rtl/spi_tx_arbiter_if.sv
// Byte-producer and serializer handshake bundle shared by the SPI TX arbiter.
// The master modport is the environment side; the slave modport is the arbiter side.
interface spi_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           ser_data;
  logic                 ser_start;
  logic                 ser_done;
  logic                 frame_en;

  modport master (
    output req_valid, req_data, req_last, ser_done,
    input  req_ready, ser_data, ser_start, frame_en
  );

  modport slave (
    input  req_valid, req_data, req_last, ser_done,
    output req_ready, ser_data, ser_start, frame_en
  );
endinterface

// File: rtl/spi_tx_arbiter.sv
// Round-robin packet arbiter feeding one SPI byte serializer, with frame enable,
// inter-frame gap and a watchdog on the serializer done handshake.
module spi_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int GW         = $clog2(NUM_REQ),
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 32
) (
  input  logic            clk,
  input  logic            rst,
  spi_tx_arbiter_if.slave bus,
  output logic [GW-1:0]   grant_id,
  output logic            busy,
  output logic            err_timeout,
  input  logic            err_clr
);
  localparam int GCW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_GAP} state_e;

  state_e           state_q, state_d;
  logic [GW-1:0]    grant_q, grant_d;
  logic [GW-1:0]    ptr_q, ptr_d;
  logic [7:0]       data_q, data_d;
  logic             last_q, last_d;
  logic             fe_q, fe_d;
  logic [7:0]       timer_q, timer_d;
  logic [GCW-1:0]   gap_q, gap_d;
  logic             err_q, err_d;
  logic             err_set;

  logic             win_found;
  logic [GW-1:0]    win_idx;
  logic [GW-1:0]    cand;

  logic [NUM_REQ-1:0]        lane_ready;
  logic [NUM_REQ-1:0]        lane_valid;
  logic [NUM_REQ-1:0]        lane_last;
  logic [NUM_REQ-1:0][7:0]   lane_data;
  logic                      sel_valid;
  logic                      sel_last;
  logic [7:0]                sel_data;

  // Each lane gates its own ready/data with the registered grant; the
  // selected byte is then an OR across lanes.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    spi_tx_arbiter_lane u_lane (
      .sel_i   (grant_q == GW'(i)),
      .load_i  (state_q == S_LOAD),
      .valid_i (bus.req_valid[i]),
      .data_i  (bus.req_data[8*i +: 8]),
      .last_i  (bus.req_last[i]),
      .ready_o (lane_ready[i]),
      .valid_o (lane_valid[i]),
      .data_o  (lane_data[i]),
      .last_o  (lane_last[i])
    );
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_valid = sel_valid | lane_valid[i];
      sel_last  = sel_last  | lane_last[i];
      sel_data  = sel_data  | lane_data[i];
    end
  end

  // Search starts one past the last winner so the previous owner goes last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = GW'((int'(ptr_q) + k) % NUM_REQ);
      if (!win_found && bus.req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    last_d  = last_q;
    fe_d    = fe_q;
    timer_d = timer_q;
    gap_d   = gap_q;
    err_set = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          grant_d = win_idx;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (sel_valid) begin
          data_d  = sel_data;
          last_d  = sel_last;
          fe_d    = 1'b1;
          timer_d = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        // Timer counts from the load pulse, so the abort lands TIMEOUT
        // cycles after ser_start.
        timer_d = timer_q + 8'd1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + 8'd1;
        if (bus.ser_done) begin
          if (last_q) begin
            state_d = S_GAP;
            fe_d    = 1'b0;
            ptr_d   = grant_q;
            gap_d   = '0;
          end else begin
            state_d = S_LOAD;
          end
        end else if (timer_q == 8'(TIMEOUT - 1)) begin
          err_set = 1'b1;
          state_d = S_GAP;
          fe_d    = 1'b0;
          ptr_d   = grant_q;
          gap_d   = '0;
        end
      end
      S_GAP: begin
        if (gap_q == GCW'(GAP_CYCLES - 1)) state_d = S_IDLE;
        else                              gap_d   = gap_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      ptr_q   <= GW'(NUM_REQ - 1);
      data_q  <= 8'h00;
      last_q  <= 1'b0;
      fe_q    <= 1'b0;
      timer_q <= 8'h00;
      gap_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      last_q  <= last_d;
      fe_q    <= fe_d;
      timer_q <= timer_d;
      gap_q   <= gap_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready = lane_ready;
  assign bus.ser_data  = data_q;
  assign bus.ser_start = (state_q == S_START);
  assign bus.frame_en  = fe_q;
  assign grant_id      = grant_q;
  assign busy          = (state_q != S_IDLE);
  assign err_timeout   = err_q;
endmodule

// Per-requester gating: ready only while loading for the granted lane, and
// the lane's byte/last/valid forced to zero unless granted.
module spi_tx_arbiter_lane (
  input  logic       sel_i,
  input  logic       load_i,
  input  logic       valid_i,
  input  logic [7:0] data_i,
  input  logic       last_i,
  output logic       ready_o,
  output logic       valid_o,
  output logic [7:0] data_o,
  output logic       last_o
);
  assign ready_o = sel_i & load_i;
  assign valid_o = sel_i & valid_i;
  assign data_o  = sel_i ? data_i : 8'h00;
  assign last_o  = sel_i & last_i;
endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Directed bench for spi_tx_arbiter: per-requester byte queues drive the bus,
// a serializer model answers ser_start, and a monitor scores each ser_start.
module tb_spi_tx_arbiter;
  localparam int NUM_REQ    = 4;
  localparam int GW         = 2;
  localparam int GAP_CYCLES = 2;
  localparam int TIMEOUT    = 32;

  typedef struct packed {
    logic [GW-1:0] gid;
    logic [7:0]    data;
  } exp_t;

  logic          clk;
  logic          rst;
  logic [GW-1:0] grant_id;
  logic          busy;
  logic          err_timeout;
  logic          err_clr;

  spi_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  spi_tx_arbiter #(
    .NUM_REQ(NUM_REQ), .GW(GW), .GAP_CYCLES(GAP_CYCLES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .grant_id(grant_id),
    .busy(busy), .err_timeout(err_timeout), .err_clr(err_clr)
  );

  int total = 0;
  int bad   = 0;

  exp_t               sb [$];
  logic [8:0]         rq [NUM_REQ][$];
  logic [NUM_REQ-1:0] stall = '0;
  logic [NUM_REQ-1:0] take;
  bit                 ser_auto = 1'b1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input int g, input logic [7:0] d);
    exp_t e;
    e.gid  = GW'(g);
    e.data = d;
    return e;
  endfunction

  // Requester model: present head of each queue, pop once accepted.
  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    take = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++)
        if (take[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      for (int i = 0; i < NUM_REQ; i++) begin
        if (rq[i].size() > 0 && !stall[i]) begin
          bus.req_valid[i]       = 1'b1;
          bus.req_data[8*i +: 8] = rq[i][0][7:0];
          bus.req_last[i]        = rq[i][0][8];
        end else begin
          bus.req_valid[i]       = 1'b0;
          bus.req_data[8*i +: 8] = 8'h00;
          bus.req_last[i]        = 1'b0;
        end
      end
      take = bus.req_valid & bus.req_ready;
    end
  end

  // Serializer model: ser_done seen by the DUT 8 cycles after ser_start.
  initial begin
    bus.ser_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && ser_auto && bus.ser_start) begin
        repeat (8) @(negedge clk);
        bus.ser_done = 1'b1;
        @(negedge clk);
        bus.ser_done = 1'b0;
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && bus.ser_start) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_start", {24'h0, bus.ser_data}, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("start_gid",  grant_id,     e.gid);
          chk("start_data", bus.ser_data, e.data);
        end
        chk("start_fe", bus.frame_en, 1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang want finish");
    $fatal(1);
  end

  task automatic wait_starts(input string nm, input int cnt, input int max);
    int n = 0;
    for (int c = 0; c < max && n < cnt; c++) begin
      @(negedge clk);
      if (bus.ser_start) n++;
    end
    chk(nm, n, cnt);
  endtask

  task automatic wait_drain(input string nm, input int max);
    bit done = 1'b0;
    bit qe;
    for (int c = 0; c < max && !done; c++) begin
      @(negedge clk);
      qe = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) if (rq[i].size() != 0) qe = 1'b0;
      if (qe && sb.size() == 0 && !busy) done = 1'b1;
    end
    chk(nm, done, 1);
  endtask

  task automatic watch(input int max, input int gid, output int starts, output int falls,
                       output int gap, output bit gid_bad, output bit done);
    bit seen = 1'b0;
    bit prev = 1'b0;
    starts = 0; falls = 0; gap = 0; gid_bad = 1'b0; done = 1'b0;
    for (int c = 0; c < max && !done; c++) begin
      @(negedge clk);
      if (busy && grant_id != GW'(gid)) gid_bad = 1'b1;
      if (bus.ser_start) starts++;
      if (prev && !bus.frame_en) falls++;
      if (seen && busy && !bus.frame_en) gap++;
      if (bus.frame_en) seen = 1'b1;
      prev = bus.frame_en;
      if (seen && !busy) done = 1'b1;
    end
  endtask

  initial begin
    int  st, fl, gp;
    bit  gb, dn, ok;
    rst     = 1'b0;
    err_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready",  bus.req_ready, 0);
    chk("rst_data",   bus.ser_data,  0);
    chk("rst_start",  bus.ser_start, 0);
    chk("rst_fe",     bus.frame_en,  0);
    chk("rst_busy",   busy,          0);
    chk("rst_err",    err_timeout,   0);
    chk("rst_grant",  grant_id,      0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte, cycle-accurate.
    rq[0].push_back({1'b1, 8'hA5});
    sb.push_back(mk(0, 8'hA5));
    @(negedge clk);
    chk("t1_c0_ready", bus.req_ready, 0);
    chk("t1_c0_busy",  busy, 0);
    @(negedge clk);
    chk("t1_c1_ready", bus.req_ready, 4'b0001);
    chk("t1_c1_fe",    bus.frame_en, 0);
    chk("t1_c1_grant", grant_id, 0);
    @(negedge clk);
    chk("t1_c2_start", bus.ser_start, 1);
    chk("t1_c2_fe",    bus.frame_en, 1);
    ok = 1'b1;
    for (int c = 3; c <= 10; c++) begin
      @(negedge clk);
      if (!bus.frame_en) ok = 1'b0;
    end
    chk("t1_fe_hold", ok, 1);
    @(negedge clk);
    chk("t1_c11_fe",   bus.frame_en, 0);
    chk("t1_c11_busy", busy, 1);
    @(negedge clk);
    chk("t1_c12_busy", busy, 1);
    @(negedge clk);
    chk("t1_c13_busy", busy, 0);

    // Three-byte packet from requester 2.
    rq[2].push_back({1'b0, 8'h11});
    rq[2].push_back({1'b0, 8'h22});
    rq[2].push_back({1'b1, 8'h33});
    sb.push_back(mk(2, 8'h11));
    sb.push_back(mk(2, 8'h22));
    sb.push_back(mk(2, 8'h33));
    watch(200, 2, st, fl, gp, gb, dn);
    chk("t2_done",    dn, 1);
    chk("t2_starts",  st, 3);
    chk("t2_fe_fall", fl, 1);
    chk("t2_gap",     gp, GAP_CYCLES);
    chk("t2_gid",     gb, 0);

    // Round robin, then requester 3 joins during the second req1 grant.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rq[0].push_back({1'b1, 8'hA0});
    rq[0].push_back({1'b1, 8'hA1});
    rq[0].push_back({1'b1, 8'hA2});
    rq[1].push_back({1'b1, 8'hB0});
    rq[1].push_back({1'b1, 8'hB1});
    rq[1].push_back({1'b1, 8'hB2});
    sb.push_back(mk(0, 8'hA0));
    sb.push_back(mk(1, 8'hB0));
    sb.push_back(mk(0, 8'hA1));
    sb.push_back(mk(1, 8'hB1));
    sb.push_back(mk(3, 8'hD0));
    sb.push_back(mk(0, 8'hA2));
    sb.push_back(mk(1, 8'hB2));
    wait_starts("t3_four_starts", 4, 400);
    rq[3].push_back({1'b1, 8'hD0});
    wait_drain("t3_drain", 600);

    // Requester 1 stalls mid-packet while requester 0 waits.
    rq[1].push_back({1'b0, 8'hC0});
    rq[1].push_back({1'b1, 8'hC1});
    sb.push_back(mk(1, 8'hC0));
    sb.push_back(mk(1, 8'hC1));
    sb.push_back(mk(0, 8'hE0));
    wait_starts("t4_first_start", 1, 100);
    stall[1] = 1'b1;
    rq[0].push_back({1'b1, 8'hE0});
    ok = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      if (c >= 9 && (bus.req_ready != 4'b0010 || !bus.frame_en || grant_id != 2'd1)) ok = 1'b0;
    end
    chk("t4_stall_hold", ok, 1);
    stall[1] = 1'b0;
    wait_drain("t4_drain", 300);

    // Watchdog: no ser_done.
    ser_auto = 1'b0;
    rq[3].push_back({1'b0, 8'hF0});
    sb.push_back(mk(3, 8'hF0));
    wait_starts("t5_start", 1, 100);
    repeat (TIMEOUT - 1) @(negedge clk);
    chk("t5_err_early", err_timeout, 0);
    @(negedge clk);
    chk("t5_err_set",  err_timeout, 1);
    chk("t5_fe_low",   bus.frame_en, 0);
    repeat (GAP_CYCLES) @(negedge clk);
    chk("t5_idle",     busy, 0);
    rq[3].push_back({1'b1, 8'hF1});
    sb.push_back(mk(3, 8'hF1));
    wait_starts("t5_start2", 1, 100);
    chk("t5_err_sticky", err_timeout, 1);
    repeat (TIMEOUT - 1) @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("t5_set_over_clr", err_timeout, 1);
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("t5_clr", err_timeout, 0);
    ser_auto = 1'b1;
    repeat (3) @(negedge clk);

    // Reset during WAIT of byte 2.
    rq[2].push_back({1'b0, 8'h61});
    rq[2].push_back({1'b1, 8'h62});
    sb.push_back(mk(2, 8'h61));
    sb.push_back(mk(2, 8'h62));
    wait_starts("t6_two_starts", 2, 200);
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_async_data",  bus.ser_data,  0);
    chk("t6_async_fe",    bus.frame_en,  0);
    chk("t6_async_busy",  busy,          0);
    chk("t6_async_ready", bus.req_ready, 0);
    chk("t6_async_grant", grant_id,      0);
    chk("t6_async_start", bus.ser_start, 0);
    for (int i = 0; i < NUM_REQ; i++) rq[i].delete();
    sb.delete();
    repeat (10) @(negedge clk);
    rst = 1'b1;
    rq[3].push_back({1'b1, 8'h73});
    rq[0].push_back({1'b1, 8'h70});
    sb.push_back(mk(0, 8'h70));
    sb.push_back(mk(3, 8'h73));
    wait_drain("t6_drain", 300);

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_tx_arbiter.md
Name: spi_tx_arbiter

Overview:
- Round-robin scheduler that shares the single SPI output serializer between NUM_REQ byte producers (hash-table output lanes).
- Grants one requester for a whole packet, delimited by req_last.
- Hands each byte to the serializer with a load/done handshake and drives the frame-enable line.
- Enforces an inter-frame idle gap and a watchdog on the serializer.

Parameters:
NUM_REQ, 4, number of requesters (legal 2..8)
GW, 2, grant index width = clog2(NUM_REQ)
GAP_CYCLES, 2, idle cycles with frame_en low between packets (legal >=1)
TIMEOUT, 32, max WAIT cycles for ser_done before abort (legal 9..255)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester byte valid
req_data  input  8*NUM_REQ  byte for requester i at bits [8i+7:8i]
req_last  input  NUM_REQ  byte is last of packet (qualified by valid)
req_ready  output  NUM_REQ  one-hot accept; byte taken when valid&ready
ser_data  output  8  byte to serializer, stable from START until ser_done
ser_start  output  1  one-cycle load pulse to serializer
ser_done  input  1  serializer finished shifting current byte
frame_en  output  1  SPI enable: high for the whole packet
grant_id  output  GW  index of current/last granted requester
busy  output  1  high in any state except IDLE
err_timeout  output  1  sticky watchdog error
err_clr  input  1  clears err_timeout

Behaviour:
- Reset: rst is asynchronous and active-low. On rst=0, state=IDLE. req_ready=0, ser_data=0, ser_start=0, frame_en=0, busy=0, err_timeout=0, grant_id=0, timer=0. RR pointer=NUM_REQ-1, so requester 0 has first priority. Reset mid-frame aborts immediately; the accepted byte is discarded.
- States: IDLE, LOAD, START, WAIT, GAP. All outputs are registered or decoded from registered state only.
- IDLE:
  - If any req_valid, pick the winner: first index with valid, searching from (ptr+1) mod NUM_REQ upward with wrap.
  - Register grant_id and go to LOAD. Otherwise stay.
- LOAD:
  - req_ready[grant_id]=1; all other bits 0.
  - On req_valid[grant_id]=1: capture req_data slice into ser_data and req_last into last_flag, then go to START.
  - If valid is low, stay in LOAD with the grant held; other requesters wait; frame_en holds its value.
- START (1 cycle): ser_start=1, frame_en=1, timer cleared. Next state is WAIT. A ser_done seen in START is ignored.
- WAIT: timer increments each cycle.
  - ser_done=1 and last_flag=0: go to LOAD (frame_en stays 1).
  - ser_done=1 and last_flag=1: go to GAP.
  - ser_done=0 and timer==TIMEOUT-1: set err_timeout and go to GAP (packet aborted, remaining bytes not drained).
- GAP:
  - frame_en=0 on entry, held for GAP_CYCLES cycles.
  - ptr=grant_id, updated on GAP entry.
  - Then go to IDLE.
- Latency: req_valid rising while IDLE at cycle 0 gives req_ready at cycle 1 and ser_start/frame_en at cycle 2 (if valid is held).
- Byte spacing: ser_done at cycle d gives the next LOAD at d+1 and the next ser_start at d+2 if the byte is valid.
- First-byte LOAD has frame_en=0; LOAD states later in the packet keep frame_en=1.
- err_timeout: set has priority over err_clr in the same cycle; otherwise err_clr=1 clears it. Arbitration continues regardless of err_timeout.
- busy=0 only in IDLE. grant_id holds its last value in IDLE.
- Width rules: timer is 8 bits. ser_data is never modified while in START or WAIT.

Test Plan:
- Single byte: req0 sends 0xA5 with last=1; ser_done 8 cycles after ser_start. Expect ready at cycle 1, ser_start at cycle 2 with ser_data=0xA5, frame_en high cycles 2..10, then low for 2 cycles, busy low again at cycle 13.
- Packet: req2 sends 0x11, 0x22, 0x33 (last on 0x33), ser_done after 8 cycles each. Expect three ser_start pulses with frame_en continuously high, grant_id=2 throughout, one GAP of 2 cycles at the end.
- Round robin: req0 and req1 each continuously offer 1-byte packets after reset. Expect grant order 0,1,0,1. When req3 is added after a req1 grant, expect order 3,0,1.
- Stall: req1 drops valid for 5 cycles between byte 1 and byte 2 of a packet while req0 is valid. Expect grant held on 1, frame_en stays high, req0 not granted until req1's last byte completes.
- Timeout: ser_done never returns. Expect err_timeout=1 exactly TIMEOUT cycles after ser_start, frame_en low, state returns to IDLE. err_clr=1 in the same cycle as a new timeout leaves err_timeout=1; err_clr alone clears it.
- Reset mid-frame: assert rst=0 during WAIT of byte 2. Expect all outputs 0 asynchronously, and after release requester 0 gets first priority.
